mem_code_ctrl: RTL and testbench
================================

Name: mem_code_ctrl

Overview:
Parametrised instruction store with a streaming loader port and a registered fetch port. A host pushes a program word-by-word through a valid/ready loader. The CPU fetch stage then reads opcodes with fixed 1-cycle latency, and fetches outside the loaded program are range-checked. It sits between the program loader and the core's fetch stage and is the successor to the fixed 16x16 code memory.

Parameters:
DW, 16, opcode width in bits (>=8)
DEPTH, 16, number of code words (>=2, power of two)
NOP_WORD, 16'h0000, value returned on an erroneous fetch (DW bits)
AW = $clog2(DEPTH), localparam, address width

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
load_start  in  1  begin a new program load (pulse)
ld_valid  in  1  loader word valid
ld_data  in  DW  loader word
ld_last  in  1  marks final word of program (qualified by ld_valid)
ld_ready  out  1  loader may transfer this cycle
ld_done  out  1  1-cycle pulse when a load completes
code_len  out  AW+1  number of words in the current program
busy  out  1  high while in LOAD
fetch_req  in  1  fetch request
fetch_addr  in  AW  fetch address (the IP)
fetch_valid  out  1  response strobe, 1 cycle after fetch_req
fetch_opcode  out  DW  fetched word
fetch_err  out  1  response is invalid (qualified by fetch_valid)

Behaviour:
- States: IDLE, LOAD, READY. Reset -> IDLE.
- Reset values: ld_ready=0, ld_done=0, code_len=0, busy=0, fetch_valid=0, fetch_opcode=NOP_WORD, fetch_err=0, wptr=0. Array contents are not cleared.
- IDLE or READY, load_start=1 -> LOAD. wptr<=0, code_len<=0.
- LOAD: ld_ready=1 and busy=1. A transfer occurs on ld_valid&&ld_ready: mem[wptr]<=ld_data, wptr<=wptr+1, code_len<=wptr+1.
- LOAD exit: a transfer with ld_last=1, or a transfer at wptr==DEPTH-1 (full; ld_last ignored). Next state READY, ld_done pulses in the cycle after the final transfer, ld_ready=0 from that cycle.
- load_start while in LOAD is ignored. No words are written outside LOAD.
- Fetch: fetch_req sampled every cycle. Next cycle fetch_valid=1. fetch_valid=0 in any cycle that does not follow a fetch_req.
  - Request in READY with fetch_addr<code_len: fetch_opcode=mem[fetch_addr], fetch_err=0.
  - Otherwise (state IDLE or LOAD, or addr>=code_len): fetch_opcode=NOP_WORD, fetch_err=1.
- Simultaneous load_start and fetch_req in READY: the fetch is served from the pre-load contents and code_len. The load starts the same cycle.
- Back-to-back fetch_req: one response per cycle, fully pipelined.
- fetch_opcode holds its last value when fetch_valid=0.
- Reset mid-load: return to IDLE and code_len=0. Words already written stay in the array but are unreachable until a new load.

Optional Feature:
MEM_CODE_PARITY_EN
- Defined: each entry stores an extra even-parity bit computed from ld_data at write. On read, parity is recomputed. A mismatch on an in-range READY fetch forces fetch_err=1 and fetch_opcode=NOP_WORD. Output port par_err (1 bit, reset 0) is set sticky on a mismatch and cleared only by rst or load_start.
- Undefined: no parity storage and no par_err port. Fetch error comes from state/range only.

Test Plan:
1. rst, then fetch_req addr 0 -> next cycle fetch_valid=1, fetch_err=1, fetch_opcode=16'h0000. Check busy=0 and code_len=0.
2. load_start, stream 16'hA001,16'hA002,16'hA003 (last on third), with ld_valid held low 2 cycles between words 1 and 2 -> ld_done pulse once, code_len=3. Fetches at 0..2 return A001..A003 with err=0. Fetch at 3 returns err=1, NOP.
3. Load DEPTH=16 words with ld_last never asserted -> load ends after the 16th transfer, ld_ready=0 next cycle, code_len=16. Fetch at 15 returns the 16th word.
4. Back-to-back fetch_req at addrs 2,0,1 over 3 cycles -> 3 consecutive fetch_valid cycles in order, correct data.
5. Assert rst after 2 of 5 words -> IDLE and code_len=0. A new load of 1 word (ld_last) gives code_len=1, and fetch at 1 returns err=1.
6. In READY, assert load_start and fetch_req addr 0 in the same cycle -> response carries the old mem[0] with err=0. Next-cycle fetch returns err=1 (state LOAD).

Source files
------------

// File: rtl/mem_code_ctrl_if.sv
// Loader and fetch bus for mem_code_ctrl: master = host/fetch side, slave = code memory.
interface mem_code_ctrl_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          load_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   code_len;
  logic          busy;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_opcode;
  logic          fetch_err;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    input  ld_ready, ld_done, code_len, busy, fetch_valid, fetch_opcode, fetch_err
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    output ld_ready, ld_done, code_len, busy, fetch_valid, fetch_opcode, fetch_err
  );
endinterface

// File: rtl/mem_code_ctrl.sv
// Instruction store with a valid/ready program loader and a 1-cycle registered fetch port.
// Optional per-word even parity with sticky par_err when MEM_CODE_PARITY_EN is defined.
module mem_code_ctrl #(
  parameter int            DW       = 16,
  parameter int            DEPTH    = 16,
  parameter logic [DW-1:0] NOP_WORD = '0
) (
  input logic            clk,
  input logic            rst,
  mem_code_ctrl_if.slave bus
`ifdef MEM_CODE_PARITY_EN
  ,
  output logic           par_err
`endif
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_code_len;
  logic          r_ld_done;
  logic          r_fetch_valid;
  logic          r_fetch_err;
  logic [DW-1:0] r_fetch_opcode;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_xfer;
  logic          w_final;
  logic          w_in_range;
  logic          w_hit;
  logic [DW-1:0] w_rd_word;

  assign w_xfer     = (r_state == S_LOAD) && bus.ld_valid;
  // A full array ends the load regardless of ld_last.
  assign w_final    = bus.ld_last || (r_wptr == AW'(DEPTH - 1));
  assign w_rd_word  = r_mem[bus.fetch_addr];
  assign w_in_range = (r_state == S_READY) && ({1'b0, bus.fetch_addr} < r_code_len);

`ifdef MEM_CODE_PARITY_EN
  logic r_par [DEPTH];
  logic w_par_ok;

  assign w_par_ok = ~(^{w_rd_word, r_par[bus.fetch_addr]});
  assign w_hit    = w_in_range && w_par_ok;

  always_ff @(posedge clk) begin
    if (w_xfer && !rst) begin
      r_par[r_wptr] <= ^bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (bus.load_start && (r_state != S_LOAD))) begin
      par_err <= 1'b0;
    end else if (bus.fetch_req && w_in_range && !w_par_ok) begin
      par_err <= 1'b1;
    end
  end
`else
  assign w_hit = w_in_range;
`endif

  // Array is never cleared; reset only makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (w_xfer && !rst) begin
      r_mem[r_wptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_code_len     <= '0;
      r_ld_done      <= 1'b0;
      r_fetch_valid  <= 1'b0;
      r_fetch_opcode <= NOP_WORD;
      r_fetch_err    <= 1'b0;
    end else begin
      r_ld_done     <= 1'b0;
      r_fetch_valid <= bus.fetch_req;
      // Fetch uses the pre-edge state and length, so a same-cycle load_start sees old contents.
      if (bus.fetch_req) begin
        r_fetch_opcode <= w_hit ? w_rd_word : NOP_WORD;
        r_fetch_err    <= !w_hit;
      end
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            r_wptr     <= r_wptr + 1'b1;
            r_code_len <= {1'b0, r_wptr} + (AW + 1)'(1);
            if (w_final) begin
              r_state   <= S_READY;
              r_ld_done <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.load_start) begin
            r_state    <= S_LOAD;
            r_wptr     <= '0;
            r_code_len <= '0;
          end
        end
      endcase
    end
  end

  assign bus.ld_ready     = (r_state == S_LOAD);
  assign bus.busy         = (r_state == S_LOAD);
  assign bus.ld_done      = r_ld_done;
  assign bus.code_len     = r_code_len;
  assign bus.fetch_valid  = r_fetch_valid;
  assign bus.fetch_opcode = r_fetch_opcode;
  assign bus.fetch_err    = r_fetch_err;
endmodule

// File: tb/tb_mem_code_ctrl.sv
// Self-checking bench for mem_code_ctrl: directed plan plus random traffic vs a behavioural model.
module tb_mem_code_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [DW-1:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic rst;

  mem_code_ctrl_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

`ifdef MEM_CODE_PARITY_EN
  logic par_err;
`endif

  mem_code_ctrl #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_CODE_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: program array, length, and whether a load is open / completed.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_len = 0;
  int            m_wp = 0;
  bit            m_loading = 1'b0;
  bit            m_loaded = 1'b0;
  bit            e_valid = 1'b0;
  bit            e_err = 1'b0;
  bit            e_done = 1'b0;
  logic [DW-1:0] e_op = NOP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_loading = 1'b0;
      m_loaded  = 1'b0;
      m_len     = 0;
      m_wp      = 0;
      e_valid   = 1'b0;
      e_err     = 1'b0;
      e_done    = 1'b0;
      e_op      = NOP;
    end else begin
      e_valid = bus.fetch_req;
      if (bus.fetch_req) begin
        if (m_loaded && !m_loading && (int'(bus.fetch_addr) < m_len)) begin
          e_op  = m_mem[bus.fetch_addr];
          e_err = 1'b0;
        end else begin
          e_op  = NOP;
          e_err = 1'b1;
        end
      end
      e_done = 1'b0;
      if (m_loading) begin
        if (bus.ld_valid) begin
          m_mem[m_wp] = bus.ld_data;
          m_wp++;
          m_len = m_wp;
          if (bus.ld_last || m_wp == DEPTH) begin
            m_loading = 1'b0;
            m_loaded  = 1'b1;
            e_done    = 1'b1;
          end
        end
      end else if (bus.load_start) begin
        m_loading = 1'b1;
        m_loaded  = 1'b0;
        m_wp      = 0;
        m_len     = 0;
      end
    end
    #1;
    chk("ld_ready", 32'(bus.ld_ready), 32'(m_loading));
    chk("busy", 32'(bus.busy), 32'(m_loading));
    chk("code_len", 32'(bus.code_len), 32'(m_len));
    chk("ld_done", 32'(bus.ld_done), 32'(e_done));
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_valid));
    chk("fetch_opcode", 32'(bus.fetch_opcode), 32'(e_op));
    if (e_valid) chk("fetch_err", 32'(bus.fetch_err), 32'(e_err));
  endtask

  task automatic idle_in();
    bus.load_start = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic fetch(input int a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(a);
    step();
    bus.fetch_req  = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input bit last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    step();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1: fetch with nothing loaded
    fetch(0);
    chk("t1_valid", 32'(bus.fetch_valid), 32'd1);
    chk("t1_err", 32'(bus.fetch_err), 32'd1);
    chk("t1_op", 32'(bus.fetch_opcode), 32'h0000);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_len", 32'(bus.code_len), 32'd0);

    // 2: three-word load with a gap
    start_load();
    push(16'hA001, 1'b0);
    step();
    step();
    push(16'hA002, 1'b0);
    push(16'hA003, 1'b1);
    chk("t2_done", 32'(bus.ld_done), 32'd1);
    chk("t2_len", 32'(bus.code_len), 32'd3);
    step();
    chk("t2_done_once", 32'(bus.ld_done), 32'd0);
    fetch(0);
    chk("t2_op0", 32'(bus.fetch_opcode), 32'hA001);
    fetch(1);
    chk("t2_op1", 32'(bus.fetch_opcode), 32'hA002);
    fetch(2);
    chk("t2_op2", 32'(bus.fetch_opcode), 32'hA003);
    chk("t2_err2", 32'(bus.fetch_err), 32'd0);
    fetch(3);
    chk("t2_err3", 32'(bus.fetch_err), 32'd1);
    chk("t2_op3", 32'(bus.fetch_opcode), 32'h0000);

    // 3: full load without ld_last
    start_load();
    for (int i = 0; i < DEPTH; i++) push(16'hB000 + 16'(i), 1'b0);
    chk("t3_ready", 32'(bus.ld_ready), 32'd0);
    chk("t3_len", 32'(bus.code_len), 32'd16);
    fetch(15);
    chk("t3_op15", 32'(bus.fetch_opcode), 32'hB00F);

    // 4: back-to-back fetches
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 4'd2;
    step();
    chk("t4_a", 32'(bus.fetch_opcode), 32'hB002);
    bus.fetch_addr = 4'd0;
    step();
    chk("t4_b", 32'(bus.fetch_opcode), 32'hB000);
    bus.fetch_addr = 4'd1;
    step();
    chk("t4_c", 32'(bus.fetch_opcode), 32'hB001);
    chk("t4_valid", 32'(bus.fetch_valid), 32'd1);
    bus.fetch_req = 1'b0;

    // 5: reset in the middle of a load
    start_load();
    push(16'hD000, 1'b0);
    push(16'hD001, 1'b0);
    rst = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hD002;
    step();
    rst = 1'b0;
    idle_in();
    chk("t5_len", 32'(bus.code_len), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    start_load();
    push(16'hC0DE, 1'b1);
    chk("t5_len1", 32'(bus.code_len), 32'd1);
    fetch(1);
    chk("t5_err1", 32'(bus.fetch_err), 32'd1);
    fetch(0);
    chk("t5_op0", 32'(bus.fetch_opcode), 32'hC0DE);

    // 6: load_start and fetch in the same cycle
    bus.load_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd0;
    step();
    bus.load_start = 1'b0;
    chk("t6_op", 32'(bus.fetch_opcode), 32'hC0DE);
    chk("t6_err", 32'(bus.fetch_err), 32'd0);
    step();
    bus.fetch_req = 1'b0;
    chk("t6_err_load", 32'(bus.fetch_err), 32'd1);
    push(16'h1234, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.load_start = ($urandom_range(0, 29) == 0);
      bus.ld_valid   = $urandom_range(0, 1) == 1;
      bus.ld_data    = 16'($urandom);
      bus.ld_last    = ($urandom_range(0, 7) == 0);
      bus.fetch_req  = $urandom_range(0, 1) == 1;
      bus.fetch_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    rst = 1'b0;
    idle_in();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
